// File: rtl/tdm_sched_pkg.sv
// Shared types and constants for the time-division counter scheduler.
// Defaults describe the standard 4-channel, 8-bit configuration.
package tdm_sched_pkg;

    localparam int unsigned DEF_NCH = 4;
    localparam int unsigned DEF_W   = 8;
    localparam int unsigned DEF_CW  = $clog2(DEF_NCH);

    typedef logic [DEF_CW-1:0] ch_idx_t;
    typedef logic [DEF_W-1:0]  cnt_t;

    localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/tdm_slot_ptr.sv
// Round-robin slot pointer gated by run; provides binary and one-hot slot.
// NCH must be a power of two so the binary pointer wraps naturally.
module tdm_slot_ptr
    import tdm_sched_pkg::*;
#(
    parameter  int unsigned NCH = DEF_NCH,
    localparam int unsigned CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           i_run,
    output logic [CW-1:0]  o_slot,
    output logic [NCH-1:0] o_slot_oh
);

    logic [CW-1:0]  r_slot;
    logic [NCH-1:0] r_slot_oh;

    // Binary and one-hot pointers advance in lockstep
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot    <= '0;
            r_slot_oh <= NCH'(1);
        end else if (i_run) begin
            r_slot    <= r_slot + CW'(1);
            r_slot_oh <= {r_slot_oh[NCH-2:0], r_slot_oh[NCH-1]};
        end
    end

    assign o_slot    = r_slot;
    assign o_slot_oh = r_slot_oh;

endmodule

// File: rtl/tdm_counter_sched.sv
// NCH logical up-counters sharing one W-bit incrementer, one channel per clock.
// Wrap reloads the channel and raises a tick pulse and a sticky irq flag.
module tdm_counter_sched
    import tdm_sched_pkg::*;
#(
    parameter  int unsigned NCH = DEF_NCH,
    parameter  int unsigned W   = DEF_W,
    localparam int unsigned CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           run,
    input  logic [NCH-1:0] ch_en,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [W-1:0]   cfg_data,
    input  logic [NCH-1:0] irq_clr,
    input  logic [CW-1:0]  rd_ch,
    output logic [W-1:0]   rd_data,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] irq,
    output logic [CW-1:0]  slot
);

    localparam logic [W-1:0] CNT_TOP = '1;

    logic [W-1:0]   r_cnt [NCH];
    logic [W-1:0]   r_rld [NCH];
    logic [W-1:0]   r_rd_data;
    logic [NCH-1:0] r_tick;
    logic [NCH-1:0] r_irq;

    logic [CW-1:0]  w_slot;
    logic [NCH-1:0] w_slot_oh;
    logic [W-1:0]   w_svc_cnt;
    logic [W-1:0]   w_svc_next;
    logic           w_wrap;
    logic           w_cfg_hit;
    logic           w_svc;
    logic [NCH-1:0] w_wrap_oh;

    tdm_slot_ptr #(
        .NCH (NCH)
    ) u_slot_ptr (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_run     (run),
        .o_slot    (w_slot),
        .o_slot_oh (w_slot_oh)
    );

    // Shared datapath: one incrementer for the channel in the current slot
    always_comb begin
        w_svc_cnt  = r_cnt[w_slot];
        w_wrap     = (w_svc_cnt == CNT_TOP);
        w_cfg_hit  = cfg_we && (cfg_ch == w_slot);
        w_svc      = run && ch_en[w_slot] && !w_cfg_hit;
        w_svc_next = w_wrap ? r_rld[w_slot] : (w_svc_cnt + W'(1));
        w_wrap_oh  = (w_svc && w_wrap) ? w_slot_oh : '0;
    end

    // Count/reload storage; a config write overrides the service of its channel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
                r_rld[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_we && (cfg_ch == CW'(i))) begin
                    r_cnt[i] <= cfg_data;
                    r_rld[i] <= cfg_data;
                end else if (w_svc && w_slot_oh[i]) begin
                    r_cnt[i] <= w_svc_next;
                end
            end
        end
    end

    // Tick, sticky irq (set beats clear) and read-back register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick    <= '0;
            r_irq     <= '0;
            r_rd_data <= '0;
        end else begin
            r_tick    <= w_wrap_oh;
            r_irq     <= (r_irq & ~irq_clr) | w_wrap_oh;
            r_rd_data <= r_cnt[rd_ch];
        end
    end

    assign rd_data = r_rd_data;
    assign tick    = r_tick;
    assign irq     = r_irq;
    assign slot    = w_slot;

endmodule

// File: doc/tdm_counter_sched.md
Name: tdm_counter_sched

Overview:
- Time-division scheduler that shares one W-bit up-counter/incrementer datapath among NCH logical counter channels.
- Each channel has a stored count and a reload value. A fixed round-robin slot pointer services one channel per clock.
- On overflow, the serviced channel reloads and raises a tick pulse and a sticky IRQ flag.
- Sits between the CPU-side register file and the sound/timer logic; gives the sample-rate and envelope timers deterministic per-channel timing.

Parameters:
- NCH, 4, number of counter channels (power of two, 2..16).
- W, 8, counter and reload width in bits.
- CW, $clog2(NCH), channel index width (derived, not overridable).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  global run; 0 freezes the slot pointer and all counting.
- ch_en  in  NCH  per-channel count enable.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  CW  channel addressed by the config write.
- cfg_data  in  W  reload value; also loaded into the count.
- irq_clr  in  NCH  per-channel IRQ clear, one-cycle pulses.
- rd_ch  in  CW  channel whose count is read.
- rd_data  out  W  registered count of rd_ch.
- tick  out  NCH  one-cycle overflow pulses.
- irq  out  NCH  sticky overflow flags.
- slot  out  CW  current slot pointer, for debug and verification.

Behaviour:
- Reset (async, reset_n=0):
  - slot=0, every count=0, every reload=0.
  - tick=0, irq=0, rd_data=0.
  - Reset mid-operation discards all state immediately; counting resumes from slot 0 after release.
- Slot pointer:
  - When run=1, slot <= (slot+1) mod NCH on every edge.
  - When run=0, slot holds.
  - Each channel is serviced exactly once every NCH clocks while run=1.
- Service at an edge where run=1, slot==s, ch_en[s]=1, and no cfg write to channel s:
  - If count[s] != 2^W-1: count[s] <= count[s]+1.
  - If count[s] == 2^W-1 (wrap): count[s] <= reload[s], tick[s] <= 1, irq[s] <= 1.
- A channel with ch_en[s]=0 at its slot is skipped: its count holds and no tick is generated.
- tick is registered. It is high for exactly the one clock following the wrap edge, at most one bit set per cycle, and otherwise 0.
- Config write (cfg_we=1):
  - reload[cfg_ch] <= cfg_data and count[cfg_ch] <= cfg_data on the same edge.
  - This works regardless of run or ch_en.
  - If cfg_ch == slot in that cycle, the config write wins: no increment and no tick for that service.
- IRQ:
  - irq[s] is set on wrap and cleared by irq_clr[s].
  - If set and clear occur on the same edge, set wins.
- Read path:
  - rd_data <= count[rd_ch] on every edge, giving 1-cycle latency.
  - The value reflects count state before that edge's update.
- Arithmetic: increment is modulo 2^W through the single shared adder. No saturation; wrap always reloads.
- reload = 2^W-1: the channel wraps on every service, so tick fires every NCH clocks.

Decomposition:
- Shared package tdm_sched_pkg holds:
  - the channel-index typedef;
  - the W-bit count typedef;
  - the CNT_MAX constant ('1 of W bits).
- One natural sub-module: tdm_slot_ptr. It is the round-robin pointer with run gating and exposes the slot and a one-hot slot vector.
- Count and reload storage stay in the top module as register arrays.

Test Plan (NCH=4, W=8):
- Reset: hold reset_n=0, then release.
  - Required: slot=0, tick=0, irq=0, rd_data=0.
  - Slot advances 0,1,2,3,0 with run=1.
- Basic wrap: write ch1 reload=0xFD, then ch_en=4'b0010 and run=1 starting at slot 0.
  - Service edges 1, 5 and 9 give counts FE, FF, FD.
  - tick[1] is high only in the cycle after edge 9, and irq[1]=1.
- Skip and freeze:
  - ch_en[1]=0: the count stays at FE across 3 slot rotations, with no tick.
  - run=0 for 10 cycles: slot and all counts are unchanged.
- Collision: issue cfg_we to ch2 with data 0x10 in the same cycle slot==2, while ch2 is enabled at count 0xFF.
  - Required: count=0x10, no tick.
  - The next service gives 0x11.
- IRQ race: assert irq_clr[1] on the same edge as ch1 wraps.
  - Required: irq[1] stays 1.
  - A later irq_clr[1] alone clears it.
- Async reset mid-run: drop reset_n between clock edges while counts are nonzero.
  - Required: outputs go to 0 immediately, without waiting for a clock edge.
  - Reload values are 0 after release.
